// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner: snapshots packed BCD on load and shows one digit per slot.
// Handles leading-zero blanking, a guard gap between slots to stop ghosting, and flags non-BCD codes.
module bcd_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    err
);

    localparam int TW = $clog2(SCAN_DIV + 1);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Slot timer runs down; the elapsed position in the slot is SCAN_DIV-1-tmr_q.
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [KW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    err_q, err_d;

    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    all_zero;
    logic                    in_guard;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        shadow_d = load ? digits_in : shadow_q;

        if (tmr_q == '0) begin
            tmr_d = TW'(SCAN_DIV - 1);
            idx_d = (idx_q == KW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            tmr_d = tmr_q - 1'b1;
            idx_d = idx_q;
        end

        // blank_vec[i] is set when digits i..top are all zero; digit 0 is never blanked.
        blank_vec = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero & (shadow_q[4*i +: 4] == 4'd0);
            blank_vec[i] = all_zero;
        end

        cur_digit = shadow_q[{idx_q, 2'b00} +: 4];
        seg_d     = (blank_lz && blank_vec[idx_q]) ? 7'h00 : dec7(cur_digit);

        in_guard = (tmr_q >= TW'(SCAN_DIV - GUARD));
        an_d     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !in_guard && (idx_q == KW'(i));
        end

        err_d = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_q[4*i +: 4] > 4'd9) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q    <= TW'(SCAN_DIV - 1);
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= '0;
            an_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            err_q    <= err_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: cycle-count model checked every cycle, plus directed literal expectations.
module tb_bcd_display_scanner;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int GD = 1;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   digits_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: edges since reset release and the captured digit values.
    int         mt = 0;
    int         md [N] = '{0, 0, 0, 0};
    logic [6:0] e_seg = '0;
    logic [N-1:0] e_an = '0;
    logic       e_err = 1'b0;

    logic [6:0] cap [N];

    bcd_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int k);
        int upper;
        upper = 0;
        for (int i = k; i < N; i++) upper += md[i];
        if (blank_lz && k > 0 && upper == 0) return 7'h00;
        return SEG_TAB[md[k]];
    endfunction

    function automatic logic model_err();
        for (int i = 0; i < N; i++) if (md[i] > 9) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mt    <= 0;
            md    <= '{0, 0, 0, 0};
            e_seg <= '0;
            e_an  <= '0;
            e_err <= 1'b0;
        end else begin
            e_an  <= ((mt % SD) < GD) ? '0 : N'(1 << ((mt / SD) % N));
            e_seg <= model_seg((mt / SD) % N);
            e_err <= model_err();
            if (load) begin
                for (int i = 0; i < N; i++) md[i] <= int'((digits_in >> (4 * i)) & 16'hF);
            end
            mt <= mt + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_an",  32'(an),  32'(e_an));
            chk("model_err", 32'(err), 32'(e_err));
        end
    end

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        digits_in = v;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic capture_frame();
        for (int d = 0; d < N; d++) cap[d] = 'x;
        for (int c = 0; c < N * SD; c++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) if (an == N'(1 << d)) cap[d] = seg;
        end
    endtask

    task automatic chk_frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
        capture_frame();
        chk({name, "_d3"}, 32'(cap[3]), 32'(s3));
        chk({name, "_d2"}, 32'(cap[2]), 32'(s2));
        chk({name, "_d1"}, 32'(cap[1]), 32'(s1));
        chk({name, "_d0"}, 32'(cap[0]), 32'(s0));
    endtask

    initial begin
        logic [3:0] idle_an [16];
        logic [3:0] cnt;
        int n;
        idle_an = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                    4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};

        // Reset and idle frame
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_an",  32'(an),  32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("idle_an",  32'(an),  32'(idle_an[c]));
            chk("idle_seg", 32'(seg), 32'h3F);
        end

        // Decode sweep
        do_load(16'h1234);
        chk_frame("dec1234", 7'h06, 7'h5B, 7'h4F, 7'h66);
        chk("dec1234_err", 32'(err), 32'h0);
        do_load(16'h5678);
        chk_frame("dec5678", 7'h6D, 7'h7D, 7'h07, 7'h7F);
        do_load(16'h0009);
        chk_frame("dec0009", 7'h3F, 7'h3F, 7'h3F, 7'h6F);

        // Leading-zero blanking
        @(negedge clk);
        blank_lz = 1'b1;
        do_load(16'h0040);
        chk_frame("lz0040", 7'h00, 7'h00, 7'h66, 7'h3F);
        do_load(16'h0000);
        chk_frame("lz0000", 7'h00, 7'h00, 7'h00, 7'h3F);

        // Invalid code
        blank_lz = 1'b0;
        do_load(16'h12A4);
        chk("inv_err_lag", 32'(err), 32'h0);
        @(negedge clk);
        chk("inv_err_set", 32'(err), 32'h1);
        chk_frame("inv12A4", 7'h06, 7'h5B, 7'h40, 7'h66);
        do_load(16'h1234);
        chk("inv_err_hold", 32'(err), 32'h1);
        @(negedge clk);
        chk("inv_err_clr", 32'(err), 32'h0);

        // Counter-driven load through 8 -> 9 -> 0
        cnt = 4'd8;
        for (int s = 0; s < 3; s++) begin
            do_load({12'h000, cnt});
            capture_frame();
            chk("cnt_d0", 32'(cap[0]), 32'(SEG_TAB[cnt]));
            cnt = (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end

        // Invalid code counts as nonzero for blanking
        blank_lz = 1'b1;
        do_load(16'h0A00);
        chk_frame("lzinv", 7'h00, 7'h40, 7'h3F, 7'h3F);
        chk("lzinv_err", 32'(err), 32'h1);

        // Mid-slot reset at slot 2, p=2
        n = 0;
        while ((mt % (N * SD)) != 2 * SD + 2 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reach", 32'(n < 64), 32'h1);
        chk("midrst_pre_an", 32'(an), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_an",  32'(an),  32'h0);
        chk("midrst_seg", 32'(seg), 32'h00);
        chk("midrst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("resume_an",  32'(an),  32'(idle_an[c]));
            chk("resume_seg", 32'(seg), 32'h3F);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed seven-segment display driver that consumes packed BCD digits from the BCD counter datapath and scans them onto a common-segment, per-digit-enable display. It sits downstream of the counter as the reader of its BCD output. It captures a snapshot of the digits on a load strobe, decodes one digit per scan slot, and applies leading-zero blanking, an anti-ghosting guard interval and invalid-code flagging.

## Interface
- NUM_DIGITS, 4, number of BCD digits scanned; digit 0 is least significant
- SCAN_DIV, 1000, clock cycles per digit slot; must be >= 2
- GUARD, 2, cycles at the start of each slot with all digit enables off; must be < SCAN_DIV
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low; asserting low clears all state immediately
- digits_in  input  4*NUM_DIGITS  packed BCD, digit i at bits [4i+3:4i]
- load  input  1  capture digits_in into the shadow register on this edge
- blank_lz  input  1  enable leading-zero blanking
- seg  output  7  segments a..g on bits 0..6, active-high, registered
- an  output  NUM_DIGITS  one-hot digit enable, active-high, registered
- err  output  1  high while any shadow digit is > 9, registered

## Operation
- Shadow register: loads digits_in on any edge with load=1. Otherwise it holds. Loading does not restart the scan.
- Prescaler p counts 0..SCAN_DIV-1 and wraps to 0.
- Digit index k advances on the edge where p = SCAN_DIV-1, from NUM_DIGITS-1 back to 0.
- Digit enables: an = 0 when p < GUARD, else one-hot(k).
- Segment decode of shadow digit k:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - codes 10-15 = 0x40 (dash, segment g only)
- Leading-zero blanking: with blank_lz=1, digit k (k>0) is blanked when shadow digits NUM_DIGITS-1 down to k are all 0.
  - A blanked digit drives seg = 0x00; its an bit still follows the normal rule.
  - Digit 0 is never blanked, so an all-zero value shows a single "0".
  - An invalid code counts as nonzero for blanking purposes.
- err = OR over shadow digits of (digit > 9). It is recomputed every cycle and clears once a valid value is loaded.
- Simultaneous load and slot change: the new index and the new shadow value both take effect together.

## Timing
- Reset values: seg=0x00, an=0, err=0, p=0, k=0, shadow=0.
- seg and an are registered from the current p, k and shadow, so they lag the internal state by one cycle.
- After reset release:
  - the first edge has p=0, so an=0 is registered;
  - an first equals one-hot(0) on the edge after p reaches GUARD.
- Slot period is exactly SCAN_DIV cycles; a full frame is NUM_DIGITS*SCAN_DIV cycles.
- Each slot shows an=0 for GUARD cycles, then one-hot(k) for SCAN_DIV-GUARD cycles.
- Load latency: the shadow register updates on the load edge. seg, if digit k changed, and err reflect it on the following edge.
- Reset mid-slot: all outputs drop to reset values asynchronously. The scan restarts at digit 0 and p=0 on release.
- load and blank_lz are sampled every cycle; blank_lz changes appear on seg one cycle later.

## Test plan
All scenarios run with NUM_DIGITS=4, SCAN_DIV=4, GUARD=1.
- Reset and idle:
  - Hold reset low, then release with no load.
  - Required: seg=0x00, an=0, err=0 during reset.
  - Required after release: a 16-cycle frame of an = 0, 1, 1, 1 (slot 0), then 0, 2, 2, 2 (slot 1), then 0, 4, 4, 4, then 0, 8, 8, 8.
  - Required: seg=0x3F throughout, including on digits 1-3, since blank_lz=0.
- Decode sweep:
  - Load digits_in=16'h1234, then 16'h5678, then 16'h0009.
  - Required: per slot, seg matches the decode table, e.g. digit 0 of 1234 gives 0x66 and digit 3 gives 0x06.
  - Required: err=0 throughout.
- Leading-zero blanking:
  - With blank_lz=1, load 16'h0040.
  - Required: digits 3 and 2 give seg=0x00; digit 1 gives 0x66; digit 0 gives 0x3F.
  - Then load 16'h0000. Required: only digit 0 shows 0x3F.
- Invalid code:
  - Load 16'h12A4. Required: err=1 one cycle after the load, and digit 1 shows 0x40.
  - Load 16'h1234. Required: err returns to 0 one cycle later.
- Counter-driven load:
  - Feed the BCD counter output into digit 0 and pulse load each counter step through up-count 8→9→0.
  - Required: digit 0 displays 0x7F, 0x6F, 0x3F with a one-cycle lag.
  - Required: the scan phase is undisturbed by the loads.
- Mid-slot reset:
  - Assert reset during slot 2 with p=2.
  - Required: an=0 and seg=0x00 immediately, before the next edge.
  - Required after release: the scan resumes at slot 0 with the guard cycle first.
